// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and width helper for the fifo read-side adapter
package fifo_pkg;
  localparam int DEFAULT_DATA_LEN = 16;
  function automatic int cnt_len(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_fwft_adapter.sv
// fifo_fwft_adapter: turns the FIFO pop-then-data read port into a first-word-fall-through valid/ready stream
module fifo_fwft_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_LEN  = DEFAULT_DATA_LEN,
  parameter int BUF_DEPTH = 3,
  parameter int CNT_LEN   = cnt_len(BUF_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_LEN-1:0] fifo_data_out,
  input  logic                fifo_rd_empty,
  output logic                fifo_rd_en,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_LEN-1:0]  occupancy
);
  localparam int PTR_LEN = $clog2(BUF_DEPTH);
  localparam logic [CNT_LEN:0] DEPTH_W = (CNT_LEN + 1)'(BUF_DEPTH);
  localparam logic [PTR_LEN-1:0] LAST = PTR_LEN'(BUF_DEPTH - 1);
  logic [DATA_LEN-1:0] mem [BUF_DEPTH];
  logic [PTR_LEN-1:0] rd_ptr, wr_ptr;
  logic [CNT_LEN-1:0] count;
  logic inflight, pop;
  always_comb begin
    fifo_rd_en = !reset && !fifo_rd_empty && (({1'b0, count} + (CNT_LEN + 1)'(inflight)) < DEPTH_W);
    out_valid  = !reset && (count != '0);
    occupancy  = reset ? '0 : count;
    out_data   = mem[rd_ptr];
    pop        = out_valid && out_ready;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      count    <= count + CNT_LEN'(inflight) - CNT_LEN'(pop);
      if (inflight) begin
        mem[wr_ptr] <= fifo_data_out;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_fwft_adapter.sv
// tb_fifo_fwft_adapter: directed and randomized checks against a queue-based reference model
module tb_fifo_fwft_adapter;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] fifo_data_out;
  logic fifo_rd_empty;
  logic fifo_rd_en;
  logic [15:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [1:0] occupancy;
  fifo_fwft_adapter #(.DATA_LEN(16), .BUF_DEPTH(3)) dut (
    .clk(clk),
    .reset(reset),
    .fifo_data_out(fifo_data_out),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_en(fifo_rd_en),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  logic [15:0] fifo_q[$];
  logic [15:0] mq[$];
  logic [15:0] exp_out[$];
  int cons_cyc[$];
  bit m_inf;
  logic [15:0] m_word;
  logic [15:0] last_word;
  int npass, ntot, pops, consumed, cyc;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic push(input logic [15:0] w);
    fifo_q.push_back(w);
    exp_out.push_back(w);
    fifo_rd_empty = 1'b0;
  endtask
  task automatic step();
    bit e_en, e_val, take;
    @(negedge clk);
    e_en  = !reset && fifo_q.size() != 0 && (mq.size() + int'(m_inf)) < 3;
    e_val = !reset && mq.size() != 0;
    take  = e_val && out_ready;
    chk("rd_en", fifo_rd_en, e_en);
    chk("valid", out_valid, e_val);
    chk("occ", occupancy, reset ? 0 : mq.size());
    if (e_val) chk("data", out_data, mq[0]);
    if (take) begin
      chk("order", out_data, exp_out.size() != 0 ? exp_out[0] : 32'hDEAD_BEEF);
      if (exp_out.size() != 0) void'(exp_out.pop_front());
      last_word = out_data;
      consumed++;
      cons_cyc.push_back(cyc);
    end
    if (e_en) pops++;
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      fifo_q.delete();
      exp_out.delete();
      m_inf = 1'b0;
    end else begin
      if (take) void'(mq.pop_front());
      if (m_inf) mq.push_back(m_word);
      m_inf = e_en;
      if (e_en) m_word = fifo_q.pop_front();
    end
    fifo_data_out = e_en ? m_word : 16'($urandom);
    fifo_rd_empty = fifo_q.size() == 0;
    cyc++;
  endtask
  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (consumed < target && n < budget) begin
      step();
      n++;
    end
    chk("drain", consumed, target);
  endtask
  initial begin
    int p0, c0, tgt;
    reset = 1'b1;
    out_ready = 1'b0;
    fifo_rd_empty = 1'b1;
    fifo_data_out = '0;
    m_inf = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    repeat (10) step();
    p0 = pops;
    out_ready = 1'b1;
    push(16'h00A5);
    run_until(consumed + 1, 20);
    repeat (2) step();
    chk("single_pops", pops - p0, 1);
    chk("single_word", last_word, 16'h00A5);
    chk("single_occ", occupancy, 0);
    c0 = consumed;
    cons_cyc.delete();
    for (int i = 1; i <= 32; i++) push(16'(i));
    run_until(c0 + 32, 60);
    chk("stream_gapless", cons_cyc.size() == 32 ? cons_cyc[31] - cons_cyc[0] : -1, 31);
    out_ready = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 8; i++) push(16'(i));
    repeat (10) step();
    chk("bp_pops", pops - p0, 3);
    chk("bp_occ", occupancy, 3);
    chk("bp_head", out_data, 16'h0001);
    out_ready = 1'b1;
    run_until(consumed + 8, 40);
    chk("bp_last", last_word, 16'h0008);
    tgt = consumed + 20;
    for (int i = 0; i < 20; i++) push(16'($urandom));
    for (int n = 0; consumed < tgt && n < 200; n++) begin
      out_ready = n[0];
      step();
    end
    chk("alt_drain", consumed, tgt);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) != 0) push(16'($urandom));
      out_ready = $urandom_range(0, 3) != 0;
      step();
      chk("occ_max", occupancy <= 2'd3 && !(dut.inflight && occupancy == 2'd3), 1);
    end
    out_ready = 1'b1;
    run_until(consumed + exp_out.size(), 200);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(16'h0100 + 16'(i));
    repeat (3) step();
    chk("pre_rst_occ", occupancy, 2);
    chk("pre_rst_inf", dut.inflight, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    step();
    push(16'h1234);
    out_ready = 1'b1;
    c0 = consumed;
    run_until(c0 + 1, 20);
    chk("rst_first", last_word, 16'h1234);
    repeat (3) step();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
